controller_packetizer: RTL and testbench

CONTROLLER_PACKETIZER -- requirements
Module: controller_packetizer

---
 rtl/controller_packetizer_if.sv | 12 +
 rtl/controller_packetizer.sv | 122 ++++++++++++
 tb/tb_controller_packetizer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_packetizer_if.sv
// Byte-stream bus between the NES poll source, the packetizer and the downstream transmitter.
// The master side drives polls and the ready; the slave (packetizer) offers bytes.
interface controller_packetizer_if;
    logic       axiiv;
    logic [7:0] buttons_in;
    logic       axiov;
    logic [7:0] axiod;
    logic       axiready;

    modport master (output axiiv, buttons_in, axiready, input axiov, axiod);
    modport slave  (input axiiv, buttons_in, axiready, output axiov, axiod);
endinterface

// File: rtl/controller_packetizer.sv
// Frames NES controller polls into 4-byte packets {SYNC, seq, data, sum} with change
// detection, a one-deep pending slot and a periodic heartbeat re-send of the last state.
module controller_packetizer #(
    parameter int         HEARTBEAT_CYCLES = 6_000_000,
    parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    controller_packetizer_if.slave        bus,
    output logic                          busy,
    output logic [7:0]                    drop_count
);
    localparam int          HB_W   = $clog2(HEARTBEAT_CYCLES + 1);
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_SYNC,
        SEND_SEQ,
        SEND_DATA,
        SEND_SUM
    } state_t;

    state_t          state;
    logic            axiov_r;
    logic [7:0]      axiod_r;
    logic [7:0]      seq;
    logic [7:0]      data_r;
    logic [7:0]      last_sent;
    logic            pending_v;
    logic [7:0]      pending;
    logic [HB_W-1:0] hb_cnt;

    logic            launch;
    logic [7:0]      launch_data;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] pkt_sum(input logic [7:0] s, input logic [7:0] d);
        return SYNC_BYTE + s + d;
    endfunction

    // Launch arbitration, only acted on in IDLE: fresh poll > pending slot > heartbeat.
    always_comb begin
        launch      = 1'b0;
        launch_data = last_sent;
        if (bus.axiiv) begin
            launch      = (bus.buttons_in != last_sent);
            launch_data = bus.buttons_in;
        end else if (pending_v) begin
            launch      = (pending != last_sent);
            launch_data = pending;
        end else if (hb_cnt == HB_MAX) begin
            launch      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            axiov_r    <= 1'b0;
            axiod_r    <= 8'h00;
            seq        <= 8'h00;
            data_r     <= 8'h00;
            last_sent  <= 8'h00;
            pending_v  <= 1'b0;
            pending    <= 8'h00;
            drop_count <= 8'h00;
            hb_cnt     <= '0;
        end else begin
            // Polls arriving mid-packet park in the pending slot, overwriting any older one.
            if (state != IDLE && bus.axiiv) begin
                pending   <= bus.buttons_in;
                pending_v <= 1'b1;
                if (pending_v) drop_count <= sat_inc8(drop_count);
            end

            case (state)
                IDLE: begin
                    pending_v <= 1'b0;
                    if (hb_cnt != HB_MAX) hb_cnt <= hb_cnt + HB_W'(1);
                    if (launch) begin
                        state   <= SEND_SYNC;
                        axiov_r <= 1'b1;
                        axiod_r <= SYNC_BYTE;
                        data_r  <= launch_data;
                    end
                end
                SEND_SYNC: if (bus.axiready) begin
                    state   <= SEND_SEQ;
                    axiod_r <= seq;
                end
                SEND_SEQ: if (bus.axiready) begin
                    state   <= SEND_DATA;
                    axiod_r <= data_r;
                end
                SEND_DATA: if (bus.axiready) begin
                    state   <= SEND_SUM;
                    axiod_r <= pkt_sum(seq, data_r);
                end
                SEND_SUM: if (bus.axiready) begin
                    state     <= IDLE;
                    axiov_r   <= 1'b0;
                    axiod_r   <= 8'h00;
                    last_sent <= data_r;
                    seq       <= seq + 8'd1;
                    hb_cnt    <= '0;
                end
                default: begin
                    state   <= IDLE;
                    axiov_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.axiov = axiov_r;
    assign bus.axiod = axiod_r;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_controller_packetizer.sv
// Bench for controller_packetizer: vector table, directed corner sequences and a random
// run, all checked against a packet-queue reference model.
module tb_controller_packetizer;
    localparam int         HB   = 20;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] drop_count;

    controller_packetizer_if bus ();

    controller_packetizer #(.HEARTBEAT_CYCLES(HB), .SYNC_BYTE(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the bytes still to be offered for the current packet, plus slots.
    logic [7:0] m_q[$];
    logic [7:0] m_last, m_seq, m_pend, m_drop, m_data;
    bit         m_pv;
    int         m_hb;

    // Observed traffic
    logic [7:0] xfer[$];
    int         gaps[$];
    int         idle_run;
    logic       prev_ov;

    typedef struct {
        logic       iv;
        logic [7:0] b;
        logic       rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = 8'h00; m_seq = 8'h00; m_pend = 8'h00; m_drop = 8'h00; m_data = 8'h00;
        m_pv = 1'b0; m_hb = 0;
        idle_run = 0; prev_ov = 1'b0;
    endtask

    task automatic model_cycle(input logic iv, input logic [7:0] b, input logic rdy);
        bit         go;
        logic [7:0] d;
        logic [7:0] s;
        if (m_q.size() != 0) begin
            if (iv) begin
                if (m_pv) m_drop = (m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1;
                m_pend = b;
                m_pv   = 1'b1;
            end
            if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_last = m_data;
                    m_seq  = m_seq + 8'd1;
                    m_hb   = 0;
                end
            end
        end else begin
            go = 1'b0;
            d  = m_last;
            if (iv) begin
                go = (b != m_last); d = b;
            end else if (m_pv) begin
                go = (m_pend != m_last); d = m_pend;
            end else if (m_hb == HB - 1) begin
                go = 1'b1;
            end
            m_pv = 1'b0;
            if (go) begin
                m_data = d;
                s      = SYNC + m_seq + d;
                m_q    = '{SYNC, m_seq, d, s};
            end
            if (m_hb < HB - 1) m_hb++;
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance both.
    task automatic step(input logic iv, input logic [7:0] b, input logic rdy);
        bus.axiiv      = iv;
        bus.buttons_in = b;
        bus.axiready   = rdy;
        chk("axiov", bus.axiov, m_q.size() != 0);
        if (m_q.size() != 0) chk("axiod", bus.axiod, m_q[0]);
        chk("busy", busy, m_q.size() != 0);
        chk("drop_count", drop_count, m_drop);
        if (bus.axiov && rdy) xfer.push_back(bus.axiod);
        if (bus.axiov && !prev_ov) begin
            gaps.push_back(idle_run);
            idle_run = 0;
        end
        if (!bus.axiov) idle_run++;
        prev_ov = bus.axiov;
        model_cycle(iv, b, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_xfer(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, xfer.size(), exp.size());
        for (int i = 0; i < exp.size() && i < xfer.size(); i++)
            chk($sformatf("%s_b%0d", name, i), xfer[i], exp[i]);
    endtask

    initial begin
        bus.axiiv = 1'b0; bus.buttons_in = 8'h00; bus.axiready = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h80};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h25};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h00};
        for (int i = 7; i < 17; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_axiov", bus.axiov, 1'b0);
        chk("rst_axiod", bus.axiod, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_count, 8'h00);
        rst = 1'b0;
        model_reset();

        // First press and unchanged poll
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("tbl%0d_ov", i), bus.axiov, tbl[i].exp_ov);
            if (tbl[i].exp_ov) chk($sformatf("tbl%0d_od", i), bus.axiod, tbl[i].exp_od);
            step(tbl[i].iv, tbl[i].b, tbl[i].rdy);
        end

        // Backpressure in SEND_SEQ
        xfer.delete();
        step(1'b1, 8'h40, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ov", bus.axiov, 1'b1);
            chk("bp_hold_od", bus.axiod, 8'h01);
            step(1'b0, 8'h00, 1'b0);
        end
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk_xfer("bp", '{8'hA5, 8'h01, 8'h40, 8'hE6});

        // Overwrite of the pending slot while stalled
        xfer.delete();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h04, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("ovw_drop", drop_count, 8'd1);
        repeat (12) step(1'b0, 8'h00, 1'b1);
        chk_xfer("ovw", '{8'hA5, 8'h02, 8'h01, 8'hA8, 8'hA5, 8'h03, 8'h04, 8'hAC});
        chk("ovw_drop_after", drop_count, 8'd1);

        // Heartbeat repeats, including seq wrap
        begin
            int         npk;
            logic [7:0] es;
            logic [7:0] s;
            bit         wrapped;
            xfer.delete();
            gaps.delete();
            repeat (6240) step(1'b0, 8'h00, 1'b1);
            for (int g = 0; g < 10 && m_q.size() != 0; g++) step(1'b0, 8'h00, 1'b1);
            npk = xfer.size() / 4;
            chk("hb_pkts_enough", npk >= 254, 1'b1);
            es = 8'h04;
            wrapped = 1'b0;
            for (int k = 0; k < npk; k++) begin
                s = SYNC + es + 8'h04;
                chk($sformatf("hb%0d_sync", k), xfer[4*k], SYNC);
                chk($sformatf("hb%0d_seq", k), xfer[4*k+1], es);
                chk($sformatf("hb%0d_data", k), xfer[4*k+2], 8'h04);
                chk($sformatf("hb%0d_sum", k), xfer[4*k+3], s);
                if (k > 0 && xfer[4*k+1] == 8'h00 && xfer[4*k-3] == 8'hFF) wrapped = 1'b1;
                es = es + 8'd1;
            end
            chk("hb_wrap", wrapped, 1'b1);
            for (int i = 1; i < gaps.size(); i++) chk($sformatf("hb_gap%0d", i), gaps[i], HB);
        end

        // Reset asserted during SEND_DATA
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        bus.axiready = 1'b0;
        chk("rmp_data_ov", bus.axiov, 1'b1);
        chk("rmp_data_od", bus.axiod, 8'h33);
        #2 rst = 1'b1;
        #1;
        chk("rmp_async_ov", bus.axiov, 1'b0);
        chk("rmp_async_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        xfer.delete();
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk_xfer("rmp_quiet", '{});
        step(1'b1, 8'h55, 1'b1);
        repeat (5) step(1'b0, 8'h00, 1'b1);
        chk_xfer("rmp_next", '{8'hA5, 8'h00, 8'h55, 8'hFA});

        // Random traffic against the model
        begin
            logic [7:0] pool[4];
            pool[0] = 8'h00; pool[1] = 8'h01; pool[2] = 8'h80; pool[3] = 8'h08;
            for (int i = 0; i < 1500; i++)
                step($urandom_range(0, 4) == 0, pool[$urandom_range(0, 3)],
                     $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
